// File: rtl/tss_search_ctrl.sv
// Three-step-search motion estimation controller for one block.
// Issues candidate positions to an external SAD engine, tracks the minimum SAD
// and reports the signed offset of the best position.
// Optional macro TSS_EARLY_TERM_EN: a zero SAD ends the search immediately.
module tss_search_ctrl #(
  parameter int unsigned H     = 320,
  parameter int unsigned V     = 240,
  parameter int unsigned CW    = 10,
  parameter int unsigned BLK   = 8,
  parameter int unsigned NP    = 6,
  parameter int unsigned STEPS = 3,
  parameter int unsigned N     = 12,
  parameter int unsigned SW    = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CW-1:0]       blk_x,
  input  logic [CW-1:0]       blk_y,
  output logic                cand_valid,
  input  logic                cand_ready,
  output logic [CW-1:0]       cand_x,
  output logic [CW-1:0]       cand_y,
  input  logic                sad_valid,
  input  logic [SW-1:0]       sad,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] vec_x,
  output logic signed [N-1:0] vec_y,
  output logic [SW-1:0]       best_sad
);

  // Working width for candidate coordinates: room for sign and for overshoot past H/V.
  localparam int unsigned WW = CW + 2;
  localparam logic [STEPS-1:0] Step0 = STEPS'(1 << (STEPS - 1));
  localparam logic signed [WW-1:0] XMax = WW'(H - BLK);
  localparam logic signed [WW-1:0] YMax = WW'(V - BLK);

  if (SW < 8 + NP) begin : g_chk_sw
    $error("SW too narrow for block SAD");
  end
  if (N < STEPS + 1) begin : g_chk_n
    $error("N too narrow for search range");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StNext, StDone} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] org_x_q, org_y_q, cen_x_q, cen_y_q;
  logic [CW-1:0] best_x_q, best_y_q, cur_x_q, cur_y_q;
  logic [STEPS-1:0] step_q;
  logic [8:0] tried_q;
  logic [SW-1:0] min_sad_q;
  logic cur_center_q;
  logic signed [N-1:0] vec_x_q, vec_y_q;
  logic [SW-1:0] best_sad_q;

  logic [8:0] avail;
  logic [3:0] nxt;
  logic [CW-1:0] nxt_x, nxt_y;
  logic accept, early_hit, stop_q, last_step, better;

`ifdef TSS_EARLY_TERM_EN
  assign early_hit = sad_valid && (sad == '0);

  // Remember a zero-SAD hit so NEXT finishes instead of starting another step.
  always_ff @(posedge clk) begin
    if (rst) begin
      stop_q <= 1'b0;
    end else if (accept) begin
      stop_q <= 1'b0;
    end else if (state_q == StWait && early_hit) begin
      stop_q <= 1'b1;
    end
  end
`else
  assign early_hit = 1'b0;
  assign stop_q    = 1'b0;
`endif

  assign accept    = start && (state_q == StIdle || state_q == StDone);
  assign last_step = (step_q == STEPS'(1)) || stop_q;
  // Center wins ties: its SAD arrives after four neighbours in raster order.
  assign better    = (sad < min_sad_q) || (cur_center_q && sad == min_sad_q) || early_hit;

  // Enumerate the 3x3 offsets, mask illegal/tried ones, pick the lowest remaining index.
  always_comb begin
    logic signed [WW-1:0] ofs, tx, ty;
    logic ok;
    avail = '0;
    nxt   = '0;
    nxt_x = '0;
    nxt_y = '0;
    ofs   = WW'(step_q);
    for (int k = 8; k >= 0; k--) begin
      tx = WW'(cen_x_q);
      ty = WW'(cen_y_q);
      if (k % 3 == 0) tx = tx - ofs;
      else if (k % 3 == 2) tx = tx + ofs;
      if (k < 3) ty = ty - ofs;
      else if (k > 5) ty = ty + ofs;
      ok = !tx[WW-1] && (tx <= XMax) && !ty[WW-1] && (ty <= YMax);
      // The center's SAD is known after the first step.
      if (k == 4 && step_q != Step0) ok = 1'b0;
      avail[k] = ok && !tried_q[k];
      if (avail[k]) begin
        nxt   = 4'(k);
        nxt_x = tx[CW-1:0];
        nxt_y = ty[CW-1:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: begin
        if (!(|avail)) state_d = StNext;
        else if (cand_ready) state_d = StWait;
      end
      StWait: begin
        if (sad_valid) state_d = (early_hit || !(|avail)) ? StNext : StIssue;
      end
      StNext:  state_d = last_step ? StDone : StIssue;
      StDone:  state_d = start ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Search datapath: origin/center, step size, tried mask, running minimum, results.
  always_ff @(posedge clk) begin
    if (rst) begin
      org_x_q      <= '0;
      org_y_q      <= '0;
      cen_x_q      <= '0;
      cen_y_q      <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      step_q       <= Step0;
      tried_q      <= '0;
      min_sad_q    <= '1;
      cur_center_q <= 1'b0;
      vec_x_q      <= '0;
      vec_y_q      <= '0;
      best_sad_q   <= '0;
    end else if (accept) begin
      org_x_q   <= blk_x;
      org_y_q   <= blk_y;
      cen_x_q   <= blk_x;
      cen_y_q   <= blk_y;
      best_x_q  <= blk_x;
      best_y_q  <= blk_y;
      step_q    <= Step0;
      tried_q   <= '0;
      min_sad_q <= '1;
    end else begin
      case (state_q)
        StIssue: begin
          if ((|avail) && cand_ready) begin
            tried_q[nxt] <= 1'b1;
            cur_x_q      <= nxt_x;
            cur_y_q      <= nxt_y;
            cur_center_q <= (nxt == 4'd4);
          end
        end
        StWait: begin
          if (sad_valid && better) begin
            min_sad_q <= sad;
            best_x_q  <= cur_x_q;
            best_y_q  <= cur_y_q;
          end
        end
        StNext: begin
          cen_x_q <= best_x_q;
          cen_y_q <= best_y_q;
          tried_q <= '0;
          if (last_step) begin
            vec_x_q    <= N'(signed'({1'b0, best_x_q}) - signed'({1'b0, org_x_q}));
            vec_y_q    <= N'(signed'({1'b0, best_y_q}) - signed'({1'b0, org_y_q}));
            best_sad_q <= min_sad_q;
          end else begin
            step_q <= step_q >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cand_valid = (state_q == StIssue) && (|avail);
  assign cand_x     = cand_valid ? nxt_x : '0;
  assign cand_y     = cand_valid ? nxt_y : '0;
  assign busy       = (state_q == StIssue) || (state_q == StWait) || (state_q == StNext);
  assign done       = (state_q == StDone);
  assign vec_x      = vec_x_q;
  assign vec_y      = vec_y_q;
  assign best_sad   = best_sad_q;

endmodule

// File: tb/tb_tss_search_ctrl.sv
// Directed bench for tss_search_ctrl with a behavioural SAD engine.
module tb_tss_search_ctrl;
  localparam int CW = 10;
  localparam int SW = 14;
  localparam int N  = 12;

  logic clk = 1'b0;
  logic rst, start, cand_valid, cand_ready, sad_valid, busy, done;
  logic [CW-1:0] blk_x, blk_y, cand_x, cand_y;
  logic [SW-1:0] sad, best_sad;
  logic signed [N-1:0] vec_x, vec_y;

  int total = 0;
  int bad = 0;
  int qx[$];
  int qy[$];
  int r_done, r_lat, r_unstable;

  always #5 clk = ~clk;

  tss_search_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .blk_x(blk_x), .blk_y(blk_y),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_x(cand_x), .cand_y(cand_y),
    .sad_valid(sad_valid), .sad(sad), .busy(busy), .done(done),
    .vec_x(vec_x), .vec_y(vec_y), .best_sad(best_sad)
  );

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // mode 0: |dx-5|+|dy+3|, 1: flat 10, 2: flat 7, 3: zero only at (-4,-4)
  function automatic int model(input int mode, input int dx, input int dy);
    case (mode)
      0: return iabs(dx - 5) + iabs(dy + 3);
      1: return 10;
      2: return 7;
      default: return (dx == -4 && dy == -4) ? 0 : 50;
    endcase
  endfunction

  task automatic do_start(input int x, input int y);
    start = 1'b1;
    blk_x = CW'(x);
    blk_y = CW'(y);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Plays the SAD engine until done; busy_cyc injects a start pulse mid-search.
  task automatic run_search(input int ox, input int oy, input int mode, input bit toggle,
                            input int busy_cyc);
    int resp_pend, resp_val, last_sad, held, hx, hy;
    resp_pend = 0; resp_val = 0; last_sad = -100; held = 0; hx = 0; hy = 0;
    qx.delete(); qy.delete();
    r_done = 0; r_lat = -1; r_unstable = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      cand_ready = toggle ? cyc[0] : 1'b1;
      start = (cyc == busy_cyc);
      blk_x = '0;
      blk_y = '0;
      sad_valid = (resp_pend != 0);
      sad = SW'(resp_val);
      if (resp_pend != 0) last_sad = cyc;
      resp_pend = 0;
      if (done) begin
        r_done = 1;
        r_lat = cyc - last_sad;
        break;
      end
      if (cand_valid) begin
        if (held != 0 && (int'(cand_x) != hx || int'(cand_y) != hy)) r_unstable++;
        if (cand_ready) begin
          qx.push_back(int'(cand_x));
          qy.push_back(int'(cand_y));
          resp_pend = 1;
          resp_val = model(mode, int'(cand_x) - ox, int'(cand_y) - oy);
          held = 0;
        end else begin
          held = 1; hx = int'(cand_x); hy = int'(cand_y);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; sad_valid = 1'b0; cand_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (cand_valid !== 1'b0) begin bad++; $display("FAIL reset_cv got=%b want=0", cand_valid); end
    total++; if (vec_x !== '0 || vec_y !== '0) begin bad++; $display("FAIL reset_vec got=%0d,%0d want=0,0", vec_x, vec_y); end
    total++; if (best_sad !== '0) begin bad++; $display("FAIL reset_sad got=%0d want=0", best_sad); end
  endtask

  task automatic test_interior;
    do_start(100, 100);
    total++; if (cand_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL int_latency got cv=%b busy=%b want 1,1", cand_valid, busy); end
    total++; if (cand_x !== CW'(96) || cand_y !== CW'(96)) begin bad++; $display("FAIL int_first got=%0d,%0d want=96,96", cand_x, cand_y); end
    run_search(100, 100, 0, 1'b0, 3);
    total++; if (r_done !== 1) begin bad++; $display("FAIL int_done got=%0d want=1", r_done); end
    total++; if (qx.size() !== 25) begin bad++; $display("FAIL int_count got=%0d want=25", qx.size()); end
    total++; if (vec_x !== 12'sd5 || vec_y !== -12'sd3) begin bad++; $display("FAIL int_vec got=%0d,%0d want=5,-3", vec_x, vec_y); end
    total++; if (best_sad !== '0) begin bad++; $display("FAIL int_sad got=%0d want=0", best_sad); end
    total++; if (r_lat !== 2) begin bad++; $display("FAIL int_done_lat got=%0d want=2", r_lat); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL int_pulse got done=%b busy=%b want 0,0", done, busy); end
  endtask

  task automatic test_reset_mid;
    int hs, dseen;
    hs = 0; dseen = 0;
    do_start(100, 100);
    for (int cyc = 0; cyc < 100 && hs < 5; cyc++) begin
      cand_ready = 1'b1;
      sad_valid = 1'b0;
      if (cand_valid) hs++;
      else if (busy) sad_valid = 1'b1;
      sad = SW'(20);
      @(posedge clk); #1;
    end
    total++; if (hs !== 5) begin bad++; $display("FAIL mid_hs got=%0d want=5", hs); end
    // In the 5th WAIT: reset together with the pending SAD.
    cand_ready = 1'b0; sad_valid = 1'b1; sad = '0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) dseen++;
      @(posedge clk); #1;
      sad_valid = 1'b0;
    end
    total++; if (busy !== 1'b0 || cand_valid !== 1'b0) begin bad++; $display("FAIL mid_idle got busy=%b cv=%b want 0,0", busy, cand_valid); end
    total++; if (dseen !== 0) begin bad++; $display("FAIL mid_done got=%0d want=0", dseen); end
    total++; if (vec_x !== '0 || vec_y !== '0 || best_sad !== '0) begin bad++; $display("FAIL mid_out got=%0d,%0d,%0d want=0,0,0", vec_x, vec_y, best_sad); end
    do_start(100, 100);
    run_search(100, 100, 0, 1'b0, -1);
    total++; if (qx.size() !== 25 || vec_x !== 12'sd5 || vec_y !== -12'sd3) begin bad++; $display("FAIL mid_rerun got n=%0d vec=%0d,%0d want 25,5,-3", qx.size(), vec_x, vec_y); end
  endtask

  task automatic test_clip(input int ox, input int oy, input string tag);
    int ex[4], ey[4];
    int gx, gy, oob;
    if (ox == 0) begin ex = '{0, 4, 0, 4}; ey = '{0, 0, 4, 4}; end
    else begin ex = '{308, 312, 308, 312}; ey = '{228, 228, 232, 232}; end
    do_start(ox, oy);
    run_search(ox, oy, 1, 1'b0, -1);
    total++; if (qx.size() !== 10) begin bad++; $display("FAIL %s_count got=%0d want=10", tag, qx.size()); end
    for (int i = 0; i < 4; i++) begin
      gx = (i < qx.size()) ? qx[i] : -1;
      gy = (i < qy.size()) ? qy[i] : -1;
      total++; if (gx !== ex[i] || gy !== ey[i]) begin bad++; $display("FAIL %s_cand%0d got=%0d,%0d want=%0d,%0d", tag, i, gx, gy, ex[i], ey[i]); end
    end
    oob = 0;
    for (int i = 0; i < qx.size(); i++) if (qx[i] > 312 || qy[i] > 232) oob++;
    total++; if (oob !== 0) begin bad++; $display("FAIL %s_oob got=%0d want=0", tag, oob); end
    total++; if (vec_x !== '0 || vec_y !== '0 || best_sad !== SW'(10)) begin bad++; $display("FAIL %s_res got=%0d,%0d,%0d want=0,0,10", tag, vec_x, vec_y, best_sad); end
  endtask

  task automatic test_backpressure;
    do_start(100, 100);
    run_search(100, 100, 2, 1'b1, -1);
    total++; if (r_done !== 1 || qx.size() !== 25) begin bad++; $display("FAIL bp_count got done=%0d n=%0d want 1,25", r_done, qx.size()); end
    total++; if (r_unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", r_unstable); end
    total++; if (vec_x !== '0 || vec_y !== '0 || best_sad !== SW'(7)) begin bad++; $display("FAIL bp_res got=%0d,%0d,%0d want=0,0,7", vec_x, vec_y, best_sad); end
  endtask

`ifdef TSS_EARLY_TERM_EN
  task automatic test_early_term;
    do_start(100, 100);
    run_search(100, 100, 3, 1'b0, 2);
    total++; if (qx.size() !== 1) begin bad++; $display("FAIL et_count got=%0d want=1", qx.size()); end
    total++; if (r_lat !== 2) begin bad++; $display("FAIL et_lat got=%0d want=2", r_lat); end
    total++; if (vec_x !== -12'sd4 || vec_y !== -12'sd4 || best_sad !== '0) begin bad++; $display("FAIL et_res got=%0d,%0d,%0d want=-4,-4,0", vec_x, vec_y, best_sad); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; blk_x = '0; blk_y = '0;
    cand_ready = 1'b0; sad_valid = 1'b0; sad = '0;
    test_reset();
    test_interior();
    test_reset_mid();
    test_clip(0, 0, "corner");
    test_clip(312, 232, "far");
    test_backpressure();
`ifdef TSS_EARLY_TERM_EN
    test_early_term();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
